// File: rtl/g_nnand_filt.sv
// g_nnand_filt: registered, parametrised mixed-polarity NAND with a
// consecutive-cycle stability filter on the output.
//
// Data path: A -> (optional synchronizer) -> a_q -> polarity mask -> NAND -> filter -> YN.
// The raw NAND result must disagree with YN on FILT_CYC consecutive CE
// cycles before YN follows it. CHG pulses for one cycle when YN changes,
// and BUSY is high while the filter counter is nonzero.
//
// Optional feature macro: G_NNAND_SYNC_EN
//   defined   - free-running two-flop synchronizer on A ahead of the input
//               register (adds two edges of latency; ignores CE).
//   undefined - A feeds the input register directly.
module g_nnand_filt #(
  parameter int unsigned      WIDTH    = 3,
  parameter logic [WIDTH-1:0] INV_MASK = 3'b011,
  parameter int unsigned      FILT_CYC = 4
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic             CE,
  input  logic [WIDTH-1:0] A,
  output logic             YN,
  output logic             CHG,
  output logic             BUSY
);

  // Counter only needs to reach FILT_CYC-1; keep at least one bit so the
  // FILT_CYC=1 build still has a well-formed (always zero) counter.
  localparam int unsigned      CNT_W    = (FILT_CYC > 2) ? $clog2(FILT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] eff;
  logic             raw;
  logic             yn_q, yn_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef G_NNAND_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Free-running two-flop synchronizer; reset to INV_MASK so the raw
  // result seen downstream is 1 (matching YN) straight out of reset.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      sync1_q <= INV_MASK;
      sync2_q <= INV_MASK;
    end else begin
      sync1_q <= A;
      sync2_q <= sync1_q;
    end
  end

  assign a_in = sync2_q;
`else
  assign a_in = A;
`endif

  // Per-input polarity: a set mask bit marks an active-low pin.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pol
      assign eff[gi] = a_q[gi] ^ INV_MASK[gi];
    end
  endgenerate

  assign raw = ~&eff;

  // Next-state for input register, filter counter, output and change pulse.
  always_comb begin
    a_d   = a_q;
    yn_d  = yn_q;
    cnt_d = cnt_q;
    chg_d = 1'b0;
    if (CE) begin
      a_d = a_in;
      if (raw == yn_q) begin
        // Agreement (or a glitch that went away) restarts the count.
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        yn_d  = raw;
        cnt_d = '0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; clear puts the gate in its idle, output-high state.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      a_q   <= INV_MASK;
      yn_q  <= 1'b1;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      yn_q  <= yn_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign YN   = yn_q;
  assign CHG  = chg_q;
  assign BUSY = |cnt_q;

endmodule
